// File: rtl/pin_input_conditioner.sv
// Conditions N_CH header-pin inputs: 2-FF sync, shared tick debounce, level plus rise/fall pulses.
// Optional build macro LONG_PRESS_EN adds a per-channel long-press pulse on long_o.
module pin_input_conditioner #(
    parameter int unsigned F_CLK        = 50_000_000,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned TICK_DIV     = F_CLK / 1000,
    parameter int unsigned STABLE_TICKS = 10,
    parameter logic        IDLE_LVL     = 1'b1,
    parameter int unsigned LONG_TICKS   = 1000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] pins_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] long_o,
    output logic            tick_o
);

    localparam int unsigned PCNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned HOLD_W = 10;

    localparam bit PARAMS_OK = (F_CLK >= 1) && (N_CH >= 1) && (N_CH <= 16) && (TICK_DIV >= 2) &&
                               (STABLE_TICKS >= 2) && (STABLE_TICKS <= 15) &&
                               (LONG_TICKS >= 1) && (LONG_TICKS < 1024);

    if (!PARAMS_OK) begin : g_param_check
        $error("pin_input_conditioner: parameter out of range");
    end

    logic [PCNT_W-1:0] pcnt;
    logic [N_CH-1:0]   sync1;
    logic [N_CH-1:0]   sync2;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [N_CH-1:0]   level_d;
    logic [N_CH-1:0]   rise_d;
    logic [N_CH-1:0]   fall_d;

    // Prescaler; tick_o is registered so it is high exactly while pcnt == TICK_DIV-1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt   <= '0;
            tick_o <= 1'b0;
        end else begin
            if (pcnt == PCNT_W'(TICK_DIV - 1)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PCNT_W'(1);
            end
            tick_o <= (pcnt == PCNT_W'(TICK_DIV - 2));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= {N_CH{IDLE_LVL}};
            sync2 <= {N_CH{IDLE_LVL}};
        end else begin
            sync1 <= pins_i;
            sync2 <= sync1;
        end
    end

    // Debounce: any cycle where the synced input agrees with the level discards progress.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_o;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (sync2[i] == level_o[i]) begin
                cnt_d[i] = '0;
            end else if (tick_o) begin
                if (cnt_q[i] == CNT_W'(STABLE_TICKS - 1)) begin
                    level_d[i] = sync2[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = sync2[i];
                    fall_d[i]  = ~sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '{default: '0};
            level_o <= {N_CH{IDLE_LVL}};
            rise_o  <= '0;
            fall_o  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_o <= level_d;
            rise_o  <= rise_d;
            fall_o  <= fall_d;
        end
    end

`ifdef LONG_PRESS_EN
    logic [HOLD_W-1:0] hold_q [N_CH];
    logic [HOLD_W-1:0] hold_d [N_CH];
    logic [N_CH-1:0]   long_d;

    // Hold counter saturates at LONG_TICKS so each press yields a single pulse.
    always_comb begin
        hold_d = hold_q;
        long_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (level_o[i] == IDLE_LVL) begin
                hold_d[i] = '0;
            end else if (tick_o && (hold_q[i] != HOLD_W'(LONG_TICKS))) begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
                long_d[i] = (hold_q[i] == HOLD_W'(LONG_TICKS - 1));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '{default: '0};
            long_o <= '0;
        end else begin
            hold_q <= hold_d;
            long_o <= long_d;
        end
    end
`else
    assign long_o = '0;
`endif

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Randomized and directed bench for pin_input_conditioner against a tick-counting reference model.
module tb_pin_input_conditioner;

    localparam int unsigned NC   = 4;
    localparam int unsigned TD   = 4;
    localparam int unsigned ST   = 3;
    localparam int unsigned LT   = 5;
    localparam logic        IDLE = 1'b1;

    logic          clk_i  = 1'b0;
    logic          rst_i  = 1'b1;
    logic [NC-1:0] pins_i = '1;
    logic [NC-1:0] level_o;
    logic [NC-1:0] rise_o;
    logic [NC-1:0] fall_o;
    logic [NC-1:0] long_o;
    logic          tick_o;

    pin_input_conditioner #(
        .F_CLK       (4000),
        .N_CH        (NC),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST),
        .IDLE_LVL    (IDLE),
        .LONG_TICKS  (LT)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pins_i (pins_i),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .long_o (long_o),
        .tick_o (tick_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge n since reset consumes a tick when n % TD == 0; a level flips on the
    // tick edge that makes ST ticks inside an unbroken run of disagreeing synced samples.
    bit            m_valid = 1'b0;
    int            n;
    logic [NC-1:0] p1, p2;
    logic [NC-1:0] m_level, m_rise, m_fall, m_long;
    logic          m_tick;
    int            run_start [NC];
    int            press_u   [NC];

    always @(posedge clk_i) begin : model
        logic [NC-1:0] s;
        logic [NC-1:0] old;
        bit            tk;
        int            tc;
        if (rst_i) begin
            n = 0; p1 = '1; p2 = '1;
            m_level = {NC{IDLE}}; m_rise = '0; m_fall = '0; m_long = '0; m_tick = 1'b0;
            for (int c = 0; c < int'(NC); c++) begin
                run_start[c] = -1;
                press_u[c]   = 0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            n++;
            s   = p2;
            tk  = (n % TD == 0);
            old = m_level;
            m_rise = '0; m_fall = '0; m_long = '0;
            for (int c = 0; c < int'(NC); c++) begin
`ifdef LONG_PRESS_EN
                if (old[c] != IDLE && tk && (n / TD - press_u[c] / TD) == int'(LT)) m_long[c] = 1'b1;
`endif
                if (s[c] != old[c]) begin
                    if (run_start[c] < 0) run_start[c] = n;
                    tc = n / TD - (run_start[c] - 1) / TD;
                    if (tk && tc == int'(ST)) begin
                        m_level[c]   = s[c];
                        m_rise[c]    = s[c];
                        m_fall[c]    = ~s[c];
                        run_start[c] = -1;
                        if (s[c] != IDLE) press_u[c] = n;
                    end
                end else begin
                    run_start[c] = -1;
                end
            end
            p2 = p1;
            p1 = pins_i;
            m_tick = (n % TD == TD - 1);
        end
    end

    always @(negedge clk_i) begin
        if (m_valid) begin
            chk("level", 32'(level_o), 32'(m_level));
            chk("rise",  32'(rise_o),  32'(m_rise));
            chk("fall",  32'(fall_o),  32'(m_fall));
            chk("long",  32'(long_o),  32'(m_long));
            chk("tick",  32'(tick_o),  32'(m_tick));
        end
    end

    // sel: 0 fall, 1 rise, 2 long; k = cycles waited, -1 on timeout.
    task automatic wait_evt(input int sel, input int ch, input int max, output int k);
        logic [NC-1:0] v;
        k = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk_i);
            v = (sel == 0) ? fall_o : (sel == 1) ? rise_o : long_o;
            if (v[ch]) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int cnt;
        int first;
        int rate;
        int exp_long;

        rst_i = 1'b1; pins_i = '1;
        repeat (5) @(negedge clk_i);
        chk("rst_level", 32'(level_o), 32'h0000_000F);
        chk("rst_pulses", 32'({rise_o, fall_o, long_o, tick_o}), 32'h0);

        rst_i = 1'b0;
        k = 1;
        while (!tick_o && k < 10) begin
            @(negedge clk_i);
            k++;
        end
        chk("first_tick_cycle", 32'(k), 32'd4);

        pins_i[0] = 1'b0; pins_i[3] = 1'b0;
        wait_evt(0, 0, 20, k);
        chk("t2_fall_window", 32'(k >= 11 && k <= 14), 32'd1);
        chk("t2_fall_pair", 32'(fall_o), 32'h9);
        chk("t2_no_rise", 32'(rise_o), 32'h0);
        @(negedge clk_i);
        chk("t2_fall_one_cycle", 32'(fall_o), 32'h0);
        chk("t2_level", 32'(level_o), 32'h6);

        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            pins_i[1] = ((i / 3) % 2) != 0;
            @(negedge clk_i);
            cnt += int'(rise_o[1]) + int'(fall_o[1]) + int'(level_o[1] != 1'b1);
        end
        pins_i[1] = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            cnt += int'(rise_o[1]) + int'(fall_o[1]) + int'(level_o[1] != 1'b1);
        end
        chk("t3_glitch_activity", 32'(cnt), 32'd0);

        pins_i[0] = 1'b1; pins_i[3] = 1'b1;
        wait_evt(1, 0, 20, k);
        chk("t4_rise_window", 32'(k >= 11 && k <= 14), 32'd1);
        chk("t4_rise_pair", 32'(rise_o), 32'h9);

        pins_i[2] = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk_i);
            cnt += int'(fall_o[2]);
        end
        rst_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            cnt += int'(fall_o[2]);
        end
        chk("t5_rst_level", 32'(level_o[2]), 32'd1);
        chk("t5_no_fall", 32'(cnt), 32'd0);
        rst_i = 1'b0;
        wait_evt(0, 2, 20, k);
        chk("t5_fall_window", 32'(k >= 11 && k <= 14), 32'd1);

`ifdef LONG_PRESS_EN
        exp_long = 1;
`else
        exp_long = 0;
`endif
        pins_i[2] = 1'b1;
        wait_evt(1, 2, 20, k);
        chk("t6_release_seen", 32'(k > 0), 32'd1);
        pins_i[2] = 1'b0;
        wait_evt(0, 2, 20, k);
        chk("t6_press_seen", 32'(k > 0), 32'd1);
        cnt = 0; first = -1;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk_i);
            if (long_o[2]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk("t6_long_count", 32'(cnt), 32'(exp_long));
        if (exp_long == 1) chk("t6_long_offset", 32'(first), 32'(LT * TD));
        pins_i[2] = 1'b1;
        wait_evt(1, 2, 20, k);
        pins_i[2] = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk_i);
            cnt += int'(long_o[2]);
        end
        pins_i[2] = 1'b1;
        repeat (40) begin
            @(negedge clk_i);
            cnt += int'(long_o[2]);
        end
        chk("t6_short_press_no_long", 32'(cnt), 32'd0);

        for (int blk = 0; blk < 6; blk++) begin
            rate = int'($urandom_range(3, 40));
            for (int i = 0; i < 500; i++) begin
                @(negedge clk_i);
                for (int c = 0; c < int'(NC); c++) begin
                    if ($urandom_range(0, rate - 1) == 0) pins_i[c] = ~pins_i[c];
                end
                rst_i = ($urandom_range(0, 999) == 0);
            end
        end
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
